move_selector: RTL
==================

Name: move_selector

Overview:
- Player-input stage directly upstream of the tic-tac-toe game FSM.
- Conditions three raw pushbuttons: 2-flop synchronizer, then debounce, then rising-edge press pulse.
- Maintains a wrap-around 0..2 cursor (posicaoX, posicaoY) and rejects moves onto occupied cells.
- Offers a confirmed move to the game FSM through a valid/ready handshake.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles (after sync) required to change a debounced button level; legal range 2..2^20.

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low; 0 forces reset state immediately
btn_x  input  1  raw pushbutton, active-high, asynchronous: advance column
btn_y  input  1  raw pushbutton, active-high, asynchronous: advance row
btn_ok  input  1  raw pushbutton, active-high, asynchronous: confirm move
enable  input  1  from game FSM: 1 = player's turn
occupied  input  9  board occupancy from game FSM; bit index = 3*row + col
move_ready  input  1  game FSM accepts the offered move this cycle
posicaoX  output  2  cursor column, 0..2
posicaoY  output  2  cursor row, 0..2
move_valid  output  1  move offered; posicaoX/posicaoY are the move
reject  output  1  one-cycle pulse: confirm pressed on an occupied cell
selecting  output  1  1 while in SELECT (cursor LED blink enable)

Behaviour:
- Reset (reset=0, async): posicaoX=0, posicaoY=0, move_valid=0, reject=0, selecting=0.
  - State IDLE; synchronizers, debounced levels and debounce counters all 0.
  - Takes effect mid-handshake too; any offered move is dropped.
- Conditioning, per button, identical and independent:
  - Two-flop synchronizer produces s.
  - Debounce counter cnt and debounced level d: if s==d, cnt<=0. If s!=d and cnt==DEBOUNCE_CYCLES-1, then d<=s and cnt<=0. Otherwise cnt<=cnt+1.
  - Glitches shorter than DEBOUNCE_CYCLES synchronized cycles produce no change.
  - Press pulse p is registered and high for exactly one cycle, on the cycle after d rises 0->1. No pulse on release.
  - Latency from raw rising edge (held stable) to p high: 2 + DEBOUNCE_CYCLES + 1 cycles.
- Cursor arithmetic: press on x does posicaoX <= (posicaoX==2) ? 0 : posicaoX+1; y likewise for posicaoY. Value 3 is never produced.
- State machine:
  - IDLE:
    - selecting=0; presses discarded; cursor holds.
    - enable=1 -> SELECT next cycle.
  - SELECT:
    - selecting=1.
    - enable=0 -> IDLE; presses that cycle are ignored.
    - Else, if p_ok:
      - occupied[3*posicaoY+posicaoX]=1 -> reject=1 for one cycle, stay in SELECT.
      - Otherwise -> OFFER, with move_valid=1 from the next cycle.
    - Else, apply p_x and/or p_y; both in the same cycle both apply.
    - p_ok has priority: p_x/p_y arriving in the same cycle as p_ok are discarded, and the move uses the pre-press cursor.
  - OFFER:
    - move_valid=1; cursor frozen; all presses discarded; enable ignored.
    - Holds until move_ready=1 is sampled. Transfer occurs that cycle; move_valid=0 from the next cycle; -> IDLE.
    - Cursor is retained after transfer. Next turn starts from the last move position.
- move_ready while not in OFFER has no effect.
- reject and move_valid are never high in the same cycle.
- Debouncers run in every state, so a button held across a state change produces no extra pulse.

Test Plan:
- Reset behaviour: reset=0 mid-OFFER with move_valid=1 -> posicaoX=0, posicaoY=0 and move_valid=0 immediately, without waiting for a clock; after release, state is IDLE.
- Debounce: btn_x high for 3 cycles then low -> no change. btn_x held high 10 cycles with enable=1 -> posicaoX 0->1 exactly once, 7 cycles after the raw edge.
- Wrap: 3 clean presses of btn_x -> posicaoX 1,2,0. 4 presses of btn_y -> posicaoY 1,2,0,1. Same-cycle p_x and p_y -> both increment.
- Reject: cursor (2,1), occupied=9'b000100000 (bit 5) -> press ok -> reject high for 1 cycle, move_valid stays 0, state stays SELECT.
- Handshake: cursor (1,1), occupied=0 -> press ok -> move_valid=1, posicaoX=1, posicaoY=1. Hold move_ready=0 for 5 cycles while pressing btn_x -> outputs unchanged. Then move_ready=1 -> move_valid=0 next cycle; state IDLE.
- Turn gating: enable=0 -> presses of btn_x/btn_ok leave cursor unchanged and produce no move_valid or reject. enable=1 -> selecting=1 on the next cycle.

Source files
------------

// File: rtl/move_selector_if.sv
// Game-FSM facing bundle of the move selector: turn/board inputs and the
// cursor, reject and valid/ready move handshake.
interface move_selector_if;
  logic       enable;
  logic [8:0] occupied;
  logic       move_ready;
  logic [1:0] posicaoX;
  logic [1:0] posicaoY;
  logic       move_valid;
  logic       reject;
  logic       selecting;

  modport master (
    input  enable, occupied, move_ready,
    output posicaoX, posicaoY, move_valid, reject, selecting
  );

  modport slave (
    output enable, occupied, move_ready,
    input  posicaoX, posicaoY, move_valid, reject, selecting
  );
endinterface

// File: rtl/move_selector.sv
// Player-input stage for tic-tac-toe: conditions three pushbuttons, moves a
// wrap-around cursor and offers a confirmed move over a valid/ready handshake.
module move_selector #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            btn_x,
  input  logic            btn_y,
  input  logic            btn_ok,
  move_selector_if.master gameBus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SELECT, OFFER} selState_t;

  logic [2:0]    rawBtn;
  logic [2:0]    syncA;
  logic [2:0]    syncB;
  logic [2:0]    deb;
  logic [2:0]    debPrev;
  logic [2:0]    press;
  logic [CW-1:0] cnt [3];

  selState_t state, stateNext;
  logic [1:0] curX, curY, xNext, yNext;
  logic       rejectQ, rejectNext;
  logic [3:0] cellIdx;

  assign rawBtn = {btn_ok, btn_y, btn_x};

  // Synchronize, debounce and edge-detect each button; runs in every state so
  // a button held across a state change never yields a second pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      syncA   <= '0;
      syncB   <= '0;
      deb     <= '0;
      debPrev <= '0;
      press   <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      syncA   <= rawBtn;
      syncB   <= syncA;
      debPrev <= deb;
      press   <= deb & ~debPrev;
      for (int i = 0; i < 3; i++) begin
        if (syncB[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= syncB[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  function automatic logic [1:0] wrapInc(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  assign cellIdx = 4'(curY) * 4'd3 + 4'(curX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      curX    <= '0;
      curY    <= '0;
      rejectQ <= 1'b0;
    end else begin
      state   <= stateNext;
      curX    <= xNext;
      curY    <= yNext;
      rejectQ <= rejectNext;
    end
  end

  // Confirm has priority over cursor moves arriving in the same cycle.
  always_comb begin
    stateNext  = state;
    xNext      = curX;
    yNext      = curY;
    rejectNext = 1'b0;
    case (state)
      IDLE: begin
        if (gameBus.enable) stateNext = SELECT;
      end
      SELECT: begin
        if (!gameBus.enable) begin
          stateNext = IDLE;
        end else if (press[2]) begin
          if (gameBus.occupied[cellIdx]) rejectNext = 1'b1;
          else                           stateNext  = OFFER;
        end else begin
          if (press[0]) xNext = wrapInc(curX);
          if (press[1]) yNext = wrapInc(curY);
        end
      end
      OFFER: begin
        if (gameBus.move_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign gameBus.posicaoX   = curX;
  assign gameBus.posicaoY   = curY;
  assign gameBus.move_valid = (state == OFFER);
  assign gameBus.selecting  = (state == SELECT);
  assign gameBus.reject     = rejectQ;

endmodule
